// File: rtl/subtractor_pkg.sv
// Shared types and bit-level helpers for the serial subtractor.
// One full-subtractor cell is modelled here as two pure functions.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int DEF_WIDTH = 8;

  function automatic logic diff_bit(
    input logic x,
    input logic y,
    input logic z
  );
    return x ^ y ^ z;
  endfunction

  function automatic logic borrow_bit(
    input logic x,
    input logic y,
    input logic z
  );
    return (~x & y) | (~x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = x - y - bin.
// Single shared cell used by the serial datapath.
module full_subtractor
  import subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = diff_bit(x, y, bin);
  assign bout = borrow_bit(x, y, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock.
// Start/busy/done handshake; result held until the next completion.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, rb_q;
  logic [WIDTH-2:0] rr_q;
  logic [WIDTH-1:0] rr_d;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             d_w, bo_w;
  logic             last_w;

  full_subtractor u_fs (
    .x    (ra_q[0]),
    .y    (rb_q[0]),
    .bin  (br_q),
    .d    (d_w),
    .bout (bo_w)
  );

  // Partial result with the new bit at the MSB; full word on the last bit.
  assign rr_d   = {d_w, rr_q};
  assign last_w = (cnt_q == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)  state_d = SHIFT;
      SHIFT:   if (last_w) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      IDLE:    ;
      SHIFT:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture, serial shifting and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q   <= '0;
      rb_q   <= '0;
      rr_q   <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ra_q  <= a;
            rb_q  <= b;
            br_q  <= bin;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          ra_q  <= ra_q >> 1;
          rb_q  <= rb_q >> 1;
          rr_q  <= rr_d[WIDTH-1:1];
          br_q  <= bo_w;
          cnt_q <= cnt_q + CW'(1);
          if (last_w) begin
            diff_q <= rr_d;
            bout_q <= bo_w;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done;
  logic [7:0] diff;
  logic       bout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ndone = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (done === 1'b1) ndone++;

  function automatic void model(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       z,
    output logic [7:0] d,
    output logic       bo
  );
    int r;
    r  = int'(x) - int'(y) - int'(z);
    bo = (r < 0);
    d  = 8'((r + 512) % 256);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(
    input logic [7:0] ia,
    input logic [7:0] ib,
    input logic       ibin,
    input string      tag
  );
    int         k;
    logic [7:0] ed;
    logic       eb;
    model(ia, ib, ibin, ed, eb);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    k = 1;
    while (k <= 20) begin
      @(posedge clk); #1;
      if (done === 1'b1) break;
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'd8);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
    @(posedge clk); #1;
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] ba [3];
    logic [7:0] bb [3];
    logic [7:0] ed;
    logic       eb;
    int         k, last, snap;

    rst = 1'b1; start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, "5m3");
    run_op(8'h03, 8'h05, 1'b0, "3m5");
    run_op(8'h00, 8'h00, 1'b1, "0m0b");
    run_op(8'hFF, 8'h00, 1'b0, "FFm0");

    // Back-to-back with start held high.
    ba = '{8'h10, 8'h80, 8'h01};
    bb = '{8'h01, 8'h80, 8'h02};
    last = 0;
    snap = ndone;
    @(negedge clk);
    a = ba[0]; b = bb[0]; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      do begin
        @(posedge clk); #1; k++;
      end while (busy !== 1'b1 && k < 20);
      chk("b2b_accept", 32'(busy), 32'd1);
      @(negedge clk);
      if (i < 2) begin
        a = ba[i+1]; b = bb[i+1]; bin = 1'b0;
      end
      start = 1'b0;
      @(negedge clk);
      start = (i < 2);
      k = 0;
      do begin
        @(posedge clk); #1; k++;
      end while (done !== 1'b1 && k < 20);
      chk("b2b_done", 32'(done), 32'd1);
      model(ba[i], bb[i], 1'b0, ed, eb);
      chk("b2b_diff", 32'(diff), 32'(ed));
      chk("b2b_bout", 32'(bout), 32'(eb));
      if (i > 0) chk("b2b_spacing", 32'(cyc - last), 32'd10);
      last = cyc;
      @(posedge clk); #1;
    end
    repeat (15) @(posedge clk);
    #1;
    chk("b2b_count", 32'(ndone - snap), 32'd3);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset in the middle of an operation; start on the same edge is dropped.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    snap = ndone;
    @(posedge clk); #1;
    chk("abort_drop", 32'(busy), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(ndone - snap), 32'd0);
    run_op(8'h09, 8'h04, 1'b0, "9m4");

    // Random sweep.
    for (int n = 0; n < 1000; n++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `diff = a - b - bin` LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flop. It is the inverse-operation counterpart of the team's combinational full adder. It trades latency for area in datapaths where a parallel subtractor is too large. Operands are captured with a start/busy/done handshake, and the result is held until the next operation completes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the edge that accepts `start`.
- `b`  in  WIDTH  subtrahend; captured with `a`.
- `bin`  in  1  borrow-in; captured with `a`.
- `busy`  out  1  high while in SHIFT or DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `diff`  out  WIDTH  result, `a - b - bin` modulo 2^WIDTH.
- `bout`  out  1  final borrow; 1 iff `a < b + bin` (unsigned).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when `start` = 1:
  - load operand shift registers `ra` ← `a` and `rb` ← `b`.
  - borrow flop `br` ← `bin`; bit counter `cnt` ← 0.
- SHIFT, every cycle:
  - cell inputs: `x` = `ra[0]`, `y` = `rb[0]`, `z` = `br`.
  - `d` = x ^ y ^ z.
  - `bo` = (~x & y) | (~x & z) | (y & z).
  - `ra` and `rb` shift right; result shift register shifts right, `d` inserted at the MSB.
  - `br` ← `bo`; `cnt` ← `cnt + 1`.
- SHIFT → DONE on the cycle where `cnt` = WIDTH−1. On that same edge, `diff` ← the completed result word and `bout` ← `bo`.
- DONE → IDLE unconditionally after one cycle. `done` = 1 only in DONE.
- `cnt` width: `$clog2(WIDTH)`; it never wraps inside one operation.
- `start` in SHIFT or DONE is ignored; there is no queueing. Operands may change freely after acceptance.
- `diff` and `bout` hold their value from DONE until the next DONE.

## Timing
- Reset values:
  - state IDLE; `busy` 0; `done` 0; `diff` 0; `bout` 0.
  - `cnt` 0; `br` 0; shift registers 0.
- `start` sampled at edge E0 → `busy` = 1 from E0.
  - Bit i is computed on edge E0+1+i, for i = 0..WIDTH−1.
  - `diff`/`bout` update at edge E0+WIDTH.
  - `done` = 1 for the cycle between E0+WIDTH and E0+WIDTH+1.
  - `busy` falls at E0+WIDTH+1.
- Minimum spacing between accepted starts: WIDTH+2 edges. With `start` held high, operations run back-to-back at this period.
- `rst` mid-operation: abort on that edge, return to IDLE, no `done` pulse. `diff`/`bout` clear to 0.
- `rst` and `start` high on the same edge: reset wins; the request is dropped.

## Structure
- Package `subtractor_pkg`:
  - state enum: IDLE, SHIFT, DONE.
  - default width constant: 8.
  - functions `diff_bit(x,y,z)` and `borrow_bit(x,y,z)`.
- Sub-module `full_subtractor` (ports `x`, `y`, `bin` → `d`, `bout`), purely combinational, built on the package functions. It is instantiated once in the datapath.
- Top level holds only the FSM, counter, shift registers, and borrow flop.

## Test plan
- WIDTH=8, `a`=0x05, `b`=0x03, `bin`=0 → `diff`=0x02, `bout`=0; `done` exactly 8 edges after the accepting edge.
- `a`=0x03, `b`=0x05, `bin`=0 → `diff`=0xFE, `bout`=1.
- `a`=0x00, `b`=0x00, `bin`=1 → `diff`=0xFF, `bout`=1. Then `a`=0xFF, `b`=0x00, `bin`=0 → `diff`=0xFF, `bout`=0.
- `start` held high across 3 operations (0x10−0x01, 0x80−0x80, 0x01−0x02):
  - `done` pulses spaced 10 edges apart.
  - results 0x0F/0, 0x00/0, 0xFF/1.
  - pulses of `start` while `busy` cause no extra operations.
- `rst` asserted at bit 4 of 0xAA−0x55:
  - next cycle in IDLE, `busy`=0, `diff`=0, no `done`.
  - a subsequent 0x09−0x04 returns 0x05/0.
- Random sweep, 1000 operand triples, compared against the `(a - b - bin) mod 256` reference model, borrow included.
